// File: rtl/mem_access_stage.sv
// Memory stage: owns a word-organised data RAM with a fixed access latency.
// It performs byte/half/word loads and stores, extends load data, and flags misaligned accesses.
module mem_access_stage #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        CLK,
   input  logic        Resetn,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [2:0]  MemOp,
   input  logic [31:0] Addr,
   input  logic [31:0] Wdata,
   output logic [31:0] Do,
   output logic        Stall,
   output logic        AddrErr
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   do_q, do_d;
   logic          addr_err_q, addr_err_d;

   logic [31:0]   mem_q [DEPTH];

   logic [AW-1:0] word_idx_s;
   logic          req_s;
   logic          misalign_s;
   logic          mem_we_s;
   logic [3:0]    byte_en_s;
   logic [31:0]   wr_word_s;
   logic [31:0]   rd_word_s;
   logic [7:0]    rd_byte_s;
   logic [15:0]   rd_half_s;
   logic [31:0]   load_val_s;
   logic          unused_addr_s;

   assign req_s         = MemRd | MemWr;
   assign word_idx_s    = Addr[AW+1:2];
   assign unused_addr_s = ^Addr[31:AW+2];
   assign rd_word_s     = mem_q[word_idx_s];

   // Alignment check by access size (MemOp[1:0] = 11 behaves as a word access)
   always_comb begin
      case (MemOp[1:0])
         2'b00:   misalign_s = 1'b0;
         2'b01:   misalign_s = Addr[0];
         default: misalign_s = (Addr[1:0] != 2'b00);
      endcase
   end

   // Store lane enables and replicated write data
   always_comb begin
      byte_en_s = 4'b0000;
      wr_word_s = Wdata;
      case (MemOp[1:0])
         2'b00: begin
            byte_en_s = 4'b0001 << Addr[1:0];
            wr_word_s = {4{Wdata[7:0]}};
         end
         2'b01: begin
            byte_en_s = Addr[1] ? 4'b1100 : 4'b0011;
            wr_word_s = {2{Wdata[15:0]}};
         end
         default: begin
            byte_en_s = 4'b1111;
            wr_word_s = Wdata;
         end
      endcase
   end

   // Load lane extraction and sign/zero extension (MemOp[2] selects unsigned)
   always_comb begin
      case (Addr[1:0])
         2'b00:   rd_byte_s = rd_word_s[7:0];
         2'b01:   rd_byte_s = rd_word_s[15:8];
         2'b10:   rd_byte_s = rd_word_s[23:16];
         default: rd_byte_s = rd_word_s[31:24];
      endcase
      rd_half_s = Addr[1] ? rd_word_s[31:16] : rd_word_s[15:0];
      case (MemOp[1:0])
         2'b00: begin
            if (MemOp[2]) begin
               load_val_s = {24'h00_0000, rd_byte_s};
            end else begin
               load_val_s = {{24{rd_byte_s[7]}}, rd_byte_s};
            end
         end
         2'b01: begin
            if (MemOp[2]) begin
               load_val_s = {16'h0000, rd_half_s};
            end else begin
               load_val_s = {{16{rd_half_s[15]}}, rd_half_s};
            end
         end
         default: load_val_s = rd_word_s;
      endcase
   end

   // Next-state, latency counter and access commit at the BUSY->DONE edge
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      do_d       = do_q;
      addr_err_d = 1'b0;
      mem_we_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_s) begin
               state_d = BUSY;
               cnt_d   = 4'(LATENCY - 1);
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = DONE;
               if (misalign_s) begin
                  addr_err_d = 1'b1;
               end else if (MemWr) begin
                  mem_we_s = 1'b1;
               end else if (MemRd) begin
                  do_d = load_val_s;
               end else begin
                  do_d = do_q;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Pipeline control state and registered outputs
   always_ff @(posedge CLK) begin
      if (!Resetn) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         do_q       <= 32'h0000_0000;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         do_q       <= do_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Data RAM byte-lane writes; a reset on the commit edge discards the store
   always_ff @(posedge CLK) begin
      if (Resetn && mem_we_s) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en_s[b]) begin
               mem_q[word_idx_s][8*b +: 8] <= wr_word_s[8*b +: 8];
            end
         end
      end
   end

   assign Stall   = Resetn & (((state_q == IDLE) & req_s) | (state_q == BUSY));
   assign Do      = do_q;
   assign AddrErr = addr_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected Do/AddrErr pushed to a scoreboard at drive time,
// popped and compared in the DONE cycle.
module tb_mem_access_stage;

   localparam int LATENCY = 2;

   logic        CLK    = 1'b0;
   logic        Resetn = 1'b0;
   logic        MemRd  = 1'b0;
   logic        MemWr  = 1'b0;
   logic [2:0]  MemOp  = 3'b000;
   logic [31:0] Addr   = 32'h0;
   logic [31:0] Wdata  = 32'h0;
   logic [31:0] Do;
   logic        Stall;
   logic        AddrErr;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_do_r = 32'h0;

   typedef struct packed {
      logic [31:0] exp_do;
      logic        exp_err;
   } exp_t;

   exp_t sb_q[$];

   mem_access_stage #(.DEPTH(1024), .LATENCY(LATENCY)) dut (
      .CLK(CLK), .Resetn(Resetn), .MemRd(MemRd), .MemWr(MemWr), .MemOp(MemOp),
      .Addr(Addr), .Wdata(Wdata), .Do(Do), .Stall(Stall), .AddrErr(AddrErr)
   );

   always #5 CLK = ~CLK;

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge in an IDLE cycle; returns just after a falling edge in IDLE.
   task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] e_do, input logic e_err);
      int   n;
      exp_t e;
      sb_q.push_back('{exp_do: e_do, exp_err: e_err});
      MemRd = rd; MemWr = wr; MemOp = op; Addr = a; Wdata = wd;
      #1;
      n = 0;
      while (Stall === 1'b1 && n < 20) begin
         n++;
         @(negedge CLK); #1;
      end
      check32({tag, "/stall_len"}, 32'(n), 32'(LATENCY + 1));
      e = sb_q.pop_front();
      check32({tag, "/Do"}, Do, e.exp_do);
      check32({tag, "/AddrErr"}, {31'b0, AddrErr}, {31'b0, e.exp_err});
      MemRd = 1'b0; MemWr = 1'b0;
      @(negedge CLK); #1;
      check32({tag, "/err_pulse"}, {31'b0, AddrErr}, 32'h0);
      check32({tag, "/idle_stall"}, {31'b0, Stall}, 32'h0);
   endtask

   task automatic ld(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] exp);
      run_op(tag, 1'b1, 1'b0, op, a, 32'h0, exp, 1'b0);
      exp_do_r = exp;
   endtask

   task automatic st(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
      run_op(tag, 1'b0, 1'b1, op, a, wd, exp_do_r, 1'b0);
   endtask

   initial begin
      // Reset with a (misaligned) load held on the inputs
      Resetn = 1'b0; MemRd = 1'b1; MemOp = 3'b010; Addr = 32'h1;
      repeat (3) begin
         @(negedge CLK); #1;
         check32("rst/Stall", {31'b0, Stall}, 32'h0);
         check32("rst/Do", Do, 32'h0);
         check32("rst/AddrErr", {31'b0, AddrErr}, 32'h0);
      end
      @(negedge CLK);
      Resetn = 1'b1;
      run_op("rst_release", 1'b1, 1'b0, 3'b010, 32'h1, 32'h0, 32'h0, 1'b1);

      // Extension of byte/half loads
      st("sw10", 3'b010, 32'h10, 32'h8081_F00D);
      ld("lb10",  3'b000, 32'h10, 32'h0000_000D);
      ld("lb11",  3'b000, 32'h11, 32'hFFFF_FFF0);
      ld("lb13",  3'b000, 32'h13, 32'hFFFF_FF80);
      ld("lbu13", 3'b100, 32'h13, 32'h0000_0080);
      ld("lh12",  3'b001, 32'h12, 32'hFFFF_8081);
      ld("lh10",  3'b001, 32'h10, 32'hFFFF_F00D);
      ld("lhu10", 3'b101, 32'h10, 32'h0000_F00D);
      ld("lhu12", 3'b101, 32'h12, 32'h0000_8081);

      // Partial stores
      st("sb11", 3'b000, 32'h11, 32'h0000_00AA);
      ld("lw_sb", 3'b010, 32'h10, 32'h8081_AA0D);
      st("sh12", 3'b001, 32'h12, 32'h0000_1234);
      ld("lw_sh", 3'b010, 32'h10, 32'h1234_AA0D);
      ld("op011", 3'b011, 32'h10, 32'h1234_AA0D);
      ld("op111", 3'b111, 32'h10, 32'h1234_AA0D);

      // Misalignment: no write, Do held, one-cycle AddrErr
      run_op("lw_mis11", 1'b1, 1'b0, 3'b010, 32'h11, 32'h0, exp_do_r, 1'b1);
      st("sw20", 3'b010, 32'h20, 32'hCAFE_BABE);
      run_op("sw_mis22", 1'b0, 1'b1, 3'b010, 32'h22, 32'hFFFF_FFFF, exp_do_r, 1'b1);
      run_op("sh_mis21", 1'b0, 1'b1, 3'b001, 32'h21, 32'hFFFF_FFFF, exp_do_r, 1'b1);
      ld("lw20", 3'b010, 32'h20, 32'hCAFE_BABE);
      run_op("lh_mis23", 1'b1, 1'b0, 3'b001, 32'h23, 32'h0, exp_do_r, 1'b1);
      st("sb23", 3'b000, 32'h23, 32'h1234_5677);
      ld("lw20b", 3'b010, 32'h20, 32'h77FE_BABE);

      // MemRd and MemWr together act as a store
      run_op("rdwr30", 1'b1, 1'b1, 3'b010, 32'h30, 32'h0BAD_F00D, exp_do_r, 1'b0);
      ld("lw30", 3'b010, 32'h30, 32'h0BAD_F00D);

      // Address wrap modulo DEPTH words
      st("sw1000", 3'b010, 32'h1000, 32'h0000_0055);
      ld("lw0", 3'b010, 32'h0, 32'h0000_0055);

      // Reset on the edge that would commit a store
      st("sw40", 3'b010, 32'h40, 32'h1122_3344);
      MemWr = 1'b1; MemOp = 3'b010; Addr = 32'h40; Wdata = 32'h1;
      @(negedge CLK);
      @(negedge CLK);
      Resetn = 1'b0;
      @(negedge CLK); #1;
      check32("midrst/Stall", {31'b0, Stall}, 32'h0);
      check32("midrst/Do", Do, 32'h0);
      check32("midrst/AddrErr", {31'b0, AddrErr}, 32'h0);
      MemWr = 1'b0;
      exp_do_r = 32'h0;
      @(negedge CLK);
      Resetn = 1'b1;
      #1;
      check32("midrst/idle", {31'b0, Stall}, 32'h0);
      @(negedge CLK);
      ld("lw40", 3'b010, 32'h40, 32'h1122_3344);

      // ALU-only stream
      for (int i = 0; i < 10; i++) begin
         Addr = $urandom; Wdata = $urandom; MemOp = 3'($urandom_range(7, 0));
         @(negedge CLK); #1;
         check32("alu/Stall", {31'b0, Stall}, 32'h0);
         check32("alu/Do", Do, exp_do_r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=completion");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the pipelined CPU: performs the data-memory access for loads and stores and produces the load result `Do`. The M/WB register consumes `Do` directly. The block owns a word-organised data RAM with a configurable access latency. It stalls the upstream pipeline while an access is in flight. It supports byte, halfword and word accesses, with sign or zero extension on loads and alignment checking.

## Interface
- `DEPTH`, default 1024: data RAM size in 32-bit words; must be a power of two.
- `LATENCY`, default 2: number of BUSY cycles per access; legal range 1..15.

- `CLK`  in  1: clock. All state updates on the rising edge.
- `Resetn`  in  1: reset, synchronous, active-low.
- `MemRd`  in  1: the instruction in this stage is a load.
- `MemWr`  in  1: the instruction in this stage is a store.
- `MemOp`  in  3: access type.
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores use `MemOp[1:0]` only: 00 sb, 01 sh, 10 sw.
  - Codes 011, 110 and 111 are treated as lw/sw.
- `Addr`  in  32: byte address, normally the ALU result.
- `Wdata`  in  32: store data. The low byte or halfword is used for sb/sh.
- `Do`  out  32: registered, extended load data, fed to the M/WB register.
- `Stall`  out  1: combinational. Freezes PC, IF/ID, ID/EX and EX/M while high.
- `AddrErr`  out  1: registered. One-cycle pulse reporting a misaligned access.

## Operation
- FSM with states IDLE, BUSY and DONE. Reset state is IDLE. Counter `cnt` is 4 bits wide.
- IDLE:
  - If `MemRd|MemWr`, go to BUSY and set `cnt` = LATENCY-1.
  - Otherwise stay in IDLE; this is a pass-through with no stall.
- BUSY:
  - While `cnt` != 0, decrement `cnt`.
  - When `cnt` == 0, go to DONE and, on that same edge, perform the access using the current inputs.
- DONE: go to IDLE unconditionally. The upstream registers advance on this edge.
- `Stall` = `Resetn` & ((IDLE & (`MemRd|MemWr`)) | BUSY). It is low in DONE.
- Upstream holds `MemRd`, `MemWr`, `MemOp`, `Addr` and `Wdata` stable while `Stall` is high. Only the values present at the BUSY→DONE edge matter.
- RAM indexing: word index = `Addr[log2(DEPTH)+1:2]`. Higher address bits are ignored, so out-of-range addresses wrap modulo DEPTH. The RAM is little-endian.
- Store, performed at the BUSY→DONE edge:
  - sb writes byte lane `Addr[1:0]` with `Wdata[7:0]`.
  - sh writes lanes {`Addr[1]`*2+1 : `Addr[1]`*2} with `Wdata[15:0]`.
  - sw writes all four lanes.
  - Other lanes are untouched.
- Load, performed at the BUSY→DONE edge:
  - The selected byte or halfword is extracted from the addressed word.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
  - The result is written into `Do`.
- Alignment:
  - lh, lhu and sh require `Addr[0]`=0.
  - lw and sw require `Addr[1:0]`=00.
  - On a violation: no RAM write, `Do` unchanged, and `AddrErr`=1 for the DONE cycle only. Full latency still applies.
- `MemRd` and `MemWr` both high: the access is treated as a store only, and `Do` is unchanged.
- `Do` holds its value across non-load instructions and stores.
- RAM contents are not cleared by reset; simulation initialises them to 0.

## Timing
- Reset values: state IDLE, `cnt`=0, `Do`=0, `AddrErr`=0. `Stall` is 0 while `Resetn` is low.
- A memory instruction occupies the stage for LATENCY+2 cycles:
  - `Stall` is high for LATENCY+1 cycles (the IDLE cycle plus LATENCY BUSY cycles).
  - `Do` and `AddrErr` are valid in the DONE cycle.
- A non-memory instruction occupies the stage for 1 cycle with `Stall`=0.
- The M/WB register samples on the negative edge, so it captures `Do` in the middle of the DONE cycle.
- Back-to-back memory instructions: DONE → IDLE, and the next access raises `Stall` in the following IDLE cycle. There is no overlap.
- Reset asserted mid-BUSY: the FSM returns to IDLE on that edge, and the pending access is discarded with no RAM write and no `Do` update.

## Test plan
- Reset with `MemRd`=1 held → `Stall`=0, `Do`=0 and `AddrErr`=0 during reset. After release, `Stall` is high for exactly LATENCY+1=3 cycles.
- sw `Wdata`=0x8081_F00D to `Addr`=0x10, then:
  - lb @0x10 → `Do`=0x0000_000D.
  - lb @0x13 → 0xFFFF_FF80.
  - lbu @0x13 → 0x0000_0080.
  - lh @0x12 → 0xFFFF_8081.
  - lhu @0x10 → 0x0000_F00D.
- sb 0xAA @0x11 over word 0x8081_F00D → lw @0x10 returns 0x8081_AA0D. Then sh 0x1234 @0x12 → lw returns 0x1234_AA0D.
- Misalignment:
  - lw @0x11 → `AddrErr` pulses for 1 cycle in DONE and `Do` keeps its previous value.
  - sw 0xFFFF_FFFF @0x22 → the word at 0x20 is unchanged.
- Wrap: with DEPTH=1024, sw 0x55 @0x1000 → lw @0x0 returns 0x0000_0055.
- Reset mid-access: assert `Resetn`=0 during BUSY of sw 0x1 @0x40 → a later lw @0x40 returns the prior value, and `Stall` resumes its normal pattern after reset.
- ALU-only stream (`MemRd`=`MemWr`=0) for 10 cycles → `Stall` stays 0 and `Do` is unchanged.
